// File: rtl/time_entry_if.sv
// Keypad / timer-cascade bundle for the microwave time-entry writer.
interface time_entry_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       clear_entry;
  logic       timer_zero;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       loadn;
  logic       busy;
  logic       entry_err;

  // Keypad, controls and timer cascade side.
  modport master (
    output key_valid, key_digit, start, clear_entry, timer_zero,
    input  sec_ones, sec_tens, mins, loadn, busy, entry_err
  );

  // Time-entry writer side.
  modport slave (
    input  key_valid, key_digit, start, clear_entry, timer_zero,
    output sec_ones, sec_tens, mins, loadn, busy, entry_err
  );
endinterface

// File: rtl/time_entry.sv
// Microwave keypad writer: shifts BCD digits in right-to-left, validates
// the m:ss value on start, pulses loadn to preset the timer cascade, then
// holds off the keypad until the timer reports zero.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no digits entered, outputs zero
// ENTRY | 1 to 3 (or more) digits shifted in
// LOAD  | one cycle with loadn low, data stable on the buses
// RUN   | timer counting, keypad ignored until timer_zero
module time_entry #(
  parameter logic [3:0] TENS_MAX = 4'd5,
  parameter logic [3:0] MINS_MAX = 4'd9
) (
  input logic         clock,
  input logic         clrn,
  time_entry_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  state_t     state;
  logic [1:0] count;

  // Single registered FSM; every output is a flop, priority clear > start > key.
  always_ff @(posedge clock) begin
    if (!clrn) begin
      state         <= IDLE;
      count         <= 2'd0;
      bus.sec_ones  <= 4'd0;
      bus.sec_tens  <= 4'd0;
      bus.mins      <= 4'd0;
      bus.loadn     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.entry_err <= 1'b0;
    end else begin
      bus.entry_err <= 1'b0;
      bus.loadn     <= 1'b1;
      case (state)
        IDLE, ENTRY: begin
          if (bus.clear_entry) begin
            state        <= IDLE;
            count        <= 2'd0;
            bus.sec_ones <= 4'd0;
            bus.sec_tens <= 4'd0;
            bus.mins     <= 4'd0;
            bus.busy     <= 1'b0;
          end else if (bus.start) begin
            // Start consumes the cycle even in IDLE, so a same-cycle key is dropped.
            if (state == ENTRY) begin
              if (bus.sec_tens > TENS_MAX || bus.mins > MINS_MAX) begin
                bus.entry_err <= 1'b1;
              end else if ({bus.mins, bus.sec_tens, bus.sec_ones} != 12'd0) begin
                state     <= LOAD;
                bus.loadn <= 1'b0;
                bus.busy  <= 1'b1;
              end
            end
          end else if (bus.key_valid) begin
            if (bus.key_digit <= 4'd9) begin
              bus.mins     <= bus.sec_tens;
              bus.sec_tens <= bus.sec_ones;
              bus.sec_ones <= bus.key_digit;
              if (count != 2'd3) count <= count + 2'd1;
              state <= ENTRY;
            end else begin
              bus.entry_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          // timer_zero is meaningless here: the cascade has not loaded yet.
          if (bus.clear_entry) begin
            state        <= IDLE;
            count        <= 2'd0;
            bus.sec_ones <= 4'd0;
            bus.sec_tens <= 4'd0;
            bus.mins     <= 4'd0;
            bus.busy     <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.clear_entry || bus.timer_zero) begin
            state        <= IDLE;
            count        <= 2'd0;
            bus.sec_ones <= 4'd0;
            bus.sec_tens <= 4'd0;
            bus.mins     <= 4'd0;
            bus.busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
